// File: rtl/add_sub_pkg.sv
// ---------------------------------------------------------------------------
// add_sub_pkg
// Shared definitions for the add/subtract arbiter:
//   - state_t    : controller state encoding (IDLE, CALC, FIX, RESP)
//   - SEG_*      : active-low 7-segment constants (segment order g..a)
//   - hex_to_seg : 4-bit value to active-low 7-segment hex pattern
// ---------------------------------------------------------------------------
package add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_ONE   = 7'b1111001;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/add_sub_arbiter_serial.sv
// ---------------------------------------------------------------------------
// add_sub_serial
// One-bit full adder with a carry flop and a WIDTH-bit result shift register.
// Sum bits enter at the MSB and shift right, so after WIDTH LSB-first steps
// the first bit computed sits at sum_q[0].
//   clk, rst   : clock, asynchronous active-high reset
//   load       : start a new operation (clear sum, preset carry)
//   carry_init : carry preset value (1 for subtract, giving the +1 of ~b+1)
//   a_bit      : current operand A bit
//   b_bit      : current operand B bit, already inverted for subtract
//   sum_q      : shifted-in result bits
//   carry_q    : running carry; after WIDTH steps, the final carry out
// ---------------------------------------------------------------------------
module add_sub_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             carry_init,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic [WIDTH-1:0] sum_q,
   output logic             carry_q
);

   logic sum_bit;
   logic carry_d;

   always_comb begin
      sum_bit = a_bit ^ b_bit ^ carry_q;
      carry_d = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
   end

   // Shifts every cycle it is not loading; the controller only samples the
   // result in FIX, exactly WIDTH steps after the load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else if (load) begin
         sum_q   <= '0;
         carry_q <= carry_init;
      end else begin
         sum_q   <= {sum_bit, sum_q[WIDTH-1:1]};
         carry_q <= carry_d;
      end
   end

endmodule

// File: rtl/add_sub_arbiter.sv
// ---------------------------------------------------------------------------
// add_sub_arbiter
// Round-robin shares one bit-serial add/subtract datapath between two
// requesters and returns a sign-magnitude result tagged with the requester id.
//
// Handshake rule (all channels): a transfer happens on a rising clk edge where
// valid and ready are both 1. Requesters hold valid and operands stable until
// ready; rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   reqN_valid/ready          : request handshake, N = 0/1
//   reqN_a, reqN_b            : unsigned operands
//   reqN_sub                  : 1 = A-B, 0 = A+B
//   rsp_valid/ready           : response handshake
//   rsp_id                    : requester that issued the op
//   rsp_mag, rsp_neg          : sign-magnitude result
//   rsp_carry                 : unsigned add overflow (0 for subtract)
//   busy                      : controller not in IDLE
//   seg_mag, seg_sign         : 7-segment patterns, only when ADD_SUB_ARB_SEG_EN
//                               is defined
// Timing: accept edge, WIDTH CALC cycles, one FIX cycle, then RESP.
// ---------------------------------------------------------------------------
module add_sub_arbiter
   import add_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_mag,
   output logic             rsp_neg,
   output logic             rsp_carry,
   output logic             busy
`ifdef ADD_SUB_ARB_SEG_EN
   ,
   output logic [6:0]       seg_mag,
   output logic [6:0]       seg_sign
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sub_q;
   logic             id_q;
   logic             last_served_q;

   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_mag_q;
   logic             rsp_neg_q;
   logic             rsp_carry_q;

   logic             grant;
   logic             accept;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             sel_sub;

   logic [WIDTH-1:0] sum_w;
   logic             carry_w;
   logic [WIDTH-1:0] mag_d;
   logic             neg_d;
   logic             carry_d;

   // Grant: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      grant = 1'b0;
      if (req1_valid && (!req0_valid || !last_served_q)) grant = 1'b1;
   end

   assign req0_ready = (state_q == IDLE) && !grant;
   assign req1_ready = (state_q == IDLE) &&  grant;
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   assign sel_a   = grant ? req1_a   : req0_a;
   assign sel_b   = grant ? req1_b   : req0_b;
   assign sel_sub = grant ? req1_sub : req0_sub;

   // Operand B is kept true; inversion for subtract happens bit by bit here.
   add_sub_serial #(.WIDTH(WIDTH)) u_serial (
      .clk        (clk),
      .rst        (rst),
      .load       (accept),
      .carry_init (sel_sub),
      .a_bit      (a_q[cnt_q]),
      .b_bit      (b_q[cnt_q] ^ sub_q),
      .sum_q      (sum_w),
      .carry_q    (carry_w)
   );

   // Sign-magnitude fix-up: a borrow (carry=0) on subtract means A<B, so the
   // two's-complement result is negated.
   always_comb begin
      mag_d   = sum_w;
      neg_d   = 1'b0;
      carry_d = 1'b0;
      if (!sub_q) begin
         carry_d = carry_w;
      end else if (!carry_w) begin
         mag_d = (~sum_w) + {{(WIDTH-1){1'b0}}, 1'b1};
         neg_d = 1'b1;
      end
   end

`ifdef ADD_SUB_ARB_SEG_EN
   logic [3:0] nib_d;
   logic [6:0] seg_mag_q;
   logic [6:0] seg_sign_q;
   assign nib_d = 4'(mag_d);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         a_q           <= '0;
         b_q           <= '0;
         sub_q         <= 1'b0;
         id_q          <= 1'b0;
         last_served_q <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_mag_q     <= '0;
         rsp_neg_q     <= 1'b0;
         rsp_carry_q   <= 1'b0;
`ifdef ADD_SUB_ARB_SEG_EN
         seg_mag_q     <= SEG_BLANK;
         seg_sign_q    <= SEG_BLANK;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q           <= sel_a;
                  b_q           <= sel_b;
                  sub_q         <= sel_sub;
                  id_q          <= grant;
                  last_served_q <= grant;
                  cnt_q         <= '0;
                  state_q       <= CALC;
               end
            end
            CALC: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state_q <= FIX;
            end
            FIX: begin
               rsp_valid_q <= 1'b1;
               rsp_id_q    <= id_q;
               rsp_mag_q   <= mag_d;
               rsp_neg_q   <= neg_d;
               rsp_carry_q <= carry_d;
`ifdef ADD_SUB_ARB_SEG_EN
               seg_mag_q   <= hex_to_seg(nib_d);
               seg_sign_q  <= neg_d ? SEG_MINUS : (carry_d ? SEG_ONE : SEG_BLANK);
`endif
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_mag   = rsp_mag_q;
   assign rsp_neg   = rsp_neg_q;
   assign rsp_carry = rsp_carry_q;
   assign busy      = (state_q != IDLE);

`ifdef ADD_SUB_ARB_SEG_EN
   assign seg_mag  = seg_mag_q;
   assign seg_sign = seg_sign_q;
`endif

endmodule

// File: tb/tb_add_sub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_add_sub_arbiter
// Testbench for add_sub_arbiter at WIDTH=4. Response fields are packed as
// {id, mag, neg, carry} for the expected queue.
// ---------------------------------------------------------------------------
module tb_add_sub_arbiter;

   localparam int WIDTH = 4;
   localparam int RW    = WIDTH + 3;

   typedef logic [RW-1:0] rsp_t;

   typedef struct {
      logic             id;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             sub;
      logic [WIDTH-1:0] mag;
      logic             neg;
      logic             carry;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0_valid = 1'b0;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a = '0;
   logic [WIDTH-1:0] req0_b = '0;
   logic             req0_sub = 1'b0;
   logic             req1_valid = 1'b0;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a = '0;
   logic [WIDTH-1:0] req1_b = '0;
   logic             req1_sub = 1'b0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_mag;
   logic             rsp_neg;
   logic             rsp_carry;
   logic             busy;
`ifdef ADD_SUB_ARB_SEG_EN
   logic [6:0]       seg_mag;
   logic [6:0]       seg_sign;
`endif

   int   pass_cnt = 0;
   int   total_cnt = 0;
   rsp_t exp_q[$];

   add_sub_arbiter #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_mag    (rsp_mag),
      .rsp_neg    (rsp_neg),
      .rsp_carry  (rsp_carry),
      .busy       (busy)
`ifdef ADD_SUB_ARB_SEG_EN
      ,
      .seg_mag    (seg_mag),
      .seg_sign   (seg_sign)
`endif
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic rsp_t mk(input logic id, input logic [WIDTH-1:0] mag,
                               input logic neg, input logic carry);
      return {id, mag, neg, carry};
   endfunction

   // Reference arithmetic: plain integer add/subtract, then sign-magnitude.
   function automatic rsp_t model(input logic id, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic sub);
      int s;
      if (!sub) begin
         s = int'(a) + int'(b);
         return mk(id, WIDTH'(s), 1'b0, s >= (1 << WIDTH));
      end else if (a >= b) begin
         return mk(id, a - b, 1'b0, 1'b0);
      end else begin
         return mk(id, b - a, 1'b1, 1'b0);
      end
   endfunction

   function automatic rsp_t cur_rsp();
      return {rsp_id, rsp_mag, rsp_neg, rsp_carry};
   endfunction

   task automatic drive(input logic who, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic sub, input logic v);
      if (!who) begin
         req0_a = a; req0_b = b; req0_sub = sub; req0_valid = v;
      end else begin
         req1_a = a; req1_b = b; req1_sub = sub; req1_valid = v;
      end
   endtask

   task automatic check_rsp();
      rsp_t e;
      if (exp_q.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = exp_q.pop_front();
         check("rsp", cur_rsp(), e);
      end
   endtask

   // Called at posedge+1; returns after the accept edge (at posedge+1).
   task automatic issue(input logic who, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic sub,
                        input rsp_t exp, output bit ok);
      ok = 1'b0;
      drive(who, a, b, sub, 1'b1);
      for (int i = 0; i < 50 && !ok; i++) begin
         if (who ? req1_ready : req0_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      drive(who, a, b, sub, 1'b0);
      if (!ok) check("accept_timeout", 0, 1);
      else exp_q.push_back(exp);
   endtask

   // lat counts edges with the accept edge as edge 1.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) check("rsp_timeout", 0, 1);
      else check_rsp();
   endtask

   task automatic run_op(input logic who, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic sub, input rsp_t exp);
      bit ok;
      int lat;
      issue(who, a, b, sub, exp, ok);
      if (ok) begin
         wait_rsp(lat);
         check("latency", lat, WIDTH + 2);
         @(posedge clk); #1;   // response handshake (rsp_ready=1)
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   vec_t vecs[10];
   int   acc_ids[4];
   int   n_acc;
   int   lat;
   int   spurious;
   bit   ok;

   initial begin
      vecs[0] = '{1'b0, 4'd5,  4'd3,  1'b0, 4'd8,  1'b0, 1'b0};
      vecs[1] = '{1'b1, 4'd9,  4'd9,  1'b0, 4'd2,  1'b0, 1'b1};
      vecs[2] = '{1'b0, 4'd3,  4'd7,  1'b1, 4'd4,  1'b1, 1'b0};
      vecs[3] = '{1'b1, 4'd7,  4'd3,  1'b1, 4'd4,  1'b0, 1'b0};
      vecs[4] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd0,  1'b0, 1'b0};
      vecs[5] = '{1'b1, 4'd15, 4'd15, 1'b0, 4'd14, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 4'd0,  4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 4'd15, 4'd0,  1'b1, 4'd15, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 4'd15, 4'd1,  1'b0, 4'd0,  1'b0, 1'b1};
      vecs[9] = '{1'b1, 4'd8,  4'd8,  1'b1, 4'd0,  1'b0, 1'b0};

      // Reset state, sampled while reset is held.
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_fields", cur_rsp(), 0);
      check("rst_req0_ready", req0_ready, 1);
      check("rst_req1_ready", req1_ready, 0);
`ifdef ADD_SUB_ARB_SEG_EN
      check("rst_seg_mag", seg_mag, 7'b1111111);
      check("rst_seg_sign", seg_sign, 7'b1111111);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // Table-driven directed vectors.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub,
                mk(vecs[i].id, vecs[i].mag, vecs[i].neg, vecs[i].carry));
`ifdef ADD_SUB_ARB_SEG_EN
         if (i == 1) begin
            check("seg_mag_9p9", seg_mag, 7'b0100100);
            check("seg_sign_9p9", seg_sign, 7'b1111001);
         end
`endif
      end
      check("idle_after_table", busy, 0);

      // Random operations against the arithmetic model.
      for (int i = 0; i < 8; i++) begin
         logic             who;
         logic [WIDTH-1:0] a, b;
         logic             sub;
         who = 1'($urandom_range(0, 1));
         a   = WIDTH'($urandom_range(0, 15));
         b   = WIDTH'($urandom_range(0, 15));
         sub = 1'($urandom_range(0, 1));
         run_op(who, a, b, sub, model(who, a, b, sub));
      end

      // Arbitration: both requesters valid continuously, first grant 0.
      do_reset();
      drive(1'b0, 4'd2, 4'd1, 1'b0, 1'b1);
      drive(1'b1, 4'd6, 4'd4, 1'b1, 1'b1);
      n_acc = 0;
      for (int i = 0; i < 4; i++) acc_ids[i] = 9;
      for (int cyc = 0; cyc < 200 && (n_acc < 4 || exp_q.size() > 0); cyc++) begin
         if (n_acc >= 4) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         if (rsp_valid && rsp_ready) check_rsp();
         if (req0_valid && req0_ready) begin
            acc_ids[n_acc] = 0; n_acc++;
            exp_q.push_back(mk(1'b0, 4'd3, 1'b0, 1'b0));
         end else if (req1_valid && req1_ready) begin
            acc_ids[n_acc] = 1; n_acc++;
            exp_q.push_back(mk(1'b1, 4'd2, 1'b0, 1'b0));
         end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("arb_accepts", n_acc, 4);
      check("arb_id0", acc_ids[0], 0);
      check("arb_id1", acc_ids[1], 1);
      check("arb_id2", acc_ids[2], 0);
      check("arb_id3", acc_ids[3], 1);
      check("arb_sb_drained", exp_q.size(), 0);

      // Backpressure in RESP.
      rsp_ready = 1'b0;
      issue(1'b0, 4'd7, 4'd3, 1'b1, mk(1'b0, 4'd4, 1'b0, 1'b0), ok);
      if (ok) begin
         wait_rsp(lat);
         drive(1'b1, 4'd1, 4'd2, 1'b0, 1'b1);
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_hold", cur_rsp(), mk(1'b0, 4'd4, 1'b0, 1'b0));
            check("bp_req0_ready", req0_ready, 0);
            check("bp_req1_ready", req1_ready, 0);
         end
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         check("bp_idle_busy", busy, 0);
         check("bp_idle_valid", rsp_valid, 0);
         check("bp_idle_retain", cur_rsp(), mk(1'b0, 4'd4, 1'b0, 1'b0));
         check("bp_idle_req1_ready", req1_ready, 1);
         exp_q.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0));
         @(posedge clk); #1;
         check("bp_next_busy", busy, 1);
         req1_valid = 1'b0;
         wait_rsp(lat);
         check("bp_next_latency", lat, WIDTH + 2);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;

      // Reset in the middle of CALC.
      drive(1'b0, 4'd5, 4'd3, 1'b0, 1'b1);
      check("mid_req0_ready", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      check("mid_busy_calc", busy, 1);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", rsp_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      spurious = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) spurious++;
      end
      check("mid_no_rsp", spurious, 0);
      run_op(1'b0, 4'd3, 4'd7, 1'b1, mk(1'b0, 4'd4, 1'b1, 1'b0));
      check("final_sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/add_sub_arbiter.md
Name: add_sub_arbiter

Overview:
- Shares one bit-serial add/subtract datapath between two requesters using round-robin arbitration.
- Each request carries two unsigned WIDTH-bit operands and an op bit. The block sequences the serial adder LSB-first, then converts the result to sign-magnitude.
- Returns the result, tagged with the requester id, on a valid/ready response channel.
- Sits between the operand-entry logic (switch/button front ends) and the 7-segment display path.

Parameters:
- WIDTH, 4, operand and magnitude width in bits (2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_sub  input  1  requester 0 op: 1 = A-B, 0 = A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_id  output  1  requester that issued the operation.
- rsp_mag  output  WIDTH  result magnitude.
- rsp_neg  output  1  result negative (sub only).
- rsp_carry  output  1  unsigned add overflow (add only; 0 for sub).
- busy  output  1  state != IDLE.

Behaviour:
- Reset clears all outputs and registers to 0, puts the FSM in IDLE and sets last_served=1, so requester 0 wins the first tie. Reset takes effect immediately, in any state.
- States and transitions:
  - IDLE: go to CALC on accept.
  - CALC: lasts exactly WIDTH cycles, one bit per cycle, LSB first; then go to FIX.
  - FIX: lasts 1 cycle; then go to RESP.
  - RESP: hold until rsp_valid&rsp_ready; then go to IDLE.
- Grant logic (combinational, in IDLE only):
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester != last_served.
  - reqN_ready = (state==IDLE) && grant==N.
- Accept = reqN_valid & reqN_ready at a clock edge. On accept, latch a, b, sub and id, and set last_served=id.
- Operand B is latched as b, not ~b, so later changes to reqN_b have no effect on the operation in flight.
- Datapath:
  - Serial full adder computes a + (sub ? ~b : b) + sub.
  - Carry flop is preset to sub at accept.
  - Sum bits shift into a WIDTH-bit result register.
- FIX cycle:
  - add: rsp_mag = r, rsp_carry = final carry, rsp_neg = 0.
  - sub, final carry=1 (A>=B): rsp_mag = r, rsp_neg = 0.
  - sub, final carry=0 (A<B): rsp_mag = ~r+1, rsp_neg = 1.
- Latency: rsp_valid rises WIDTH+2 edges after the accept edge (6 cycles at WIDTH=4).
- rsp_* are registered and held stable while rsp_valid=1 and rsp_ready=0.
- After the response handshake, the next accept occurs no earlier than the following edge (no bypass). Maximum throughput is one op per WIDTH+3 cycles.
- Requests arriving during CALC/FIX/RESP are not accepted (ready=0). Requesters must hold valid and operands stable until ready.
- rsp_* outputs retain their last values in IDLE; only rsp_valid deasserts.

Optional Feature:
- Macro ADD_SUB_ARB_SEG_EN.
- Defined: adds two output ports, both registered and updated in FIX:
  - seg_mag [6:0]: active-low 7-segment hex pattern of rsp_mag[3:0].
  - seg_sign [6:0]: 7'b0111111 ("-") when neg; 7'b1111001 ("1") when carry; otherwise 7'b1111111 (blank).
  - Reset value of both ports: 7'b1111111.
- Undefined: these ports and their logic are absent.

Decomposition:
- Shared package add_sub_pkg:
  - FSM state encoding (IDLE, CALC, FIX, RESP).
  - Segment constants SEG_BLANK, SEG_MINUS, SEG_ONE.
  - hex_to_seg function (4-bit to active-low 7-bit).
- Sub-module add_sub_serial: one full adder plus carry flop and WIDTH-bit shift register.
  - Ports: clk, rst, load, carry_init, a_bit, b_bit, sum_q, carry_q.

Test Plan:
- WIDTH=4; req0 a=5 b=3 sub=0 -> rsp_valid exactly 6 edges after accept; id=0 mag=8 neg=0 carry=0.
- req1 a=9 b=9 sub=0 -> id=1 mag=2 carry=1 neg=0; with ADD_SUB_ARB_SEG_EN: seg_mag=7'b0100100, seg_sign=7'b1111001.
- Subtractions:
  - a=3 b=7 sub=1 -> mag=4 neg=1 carry=0.
  - a=7 b=3 -> mag=4 neg=0.
  - a=0 b=0 -> mag=0 neg=0.
- Arbitration: both reqs valid continuously with rsp_ready=1 -> accepted ids alternate 0,1,0,1; first is 0 after reset.
- Backpressure: rsp_ready=0 for 3 cycles in RESP -> rsp_* stable, both req readys 0; rsp_ready=1 -> IDLE next edge, next accept the edge after.
- Reset mid-CALC (cycle 2 of 4) -> busy=0 and rsp_valid=0 immediately; no response emitted for the aborted op; a fresh req0 after release gives a correct result.
